// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the host-side receiver and the CPU-side transmitter.
// Contents: receiver FSM state enum, oversampling/data-width constants, and the baud-tick divisor
// function. Build macro UART_PARITY_EN adds the PARITY state (8E1 framing).
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

  // Clocks per oversampling tick; never below 1 so the divider always advances.
  function automatic int unsigned clks_per_tick(input int unsigned sys_clk_freq,
                                                input int unsigned baud_rate);
    int unsigned d;
    d = sys_clk_freq / (baud_rate * OVERSAMPLE);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_host_rx_if.sv
// uart_host_rx_if: byte output port of the host UART receiver.
// Signals: out_data/out_valid/out_ready (valid/ready byte stream), frame_err, overrun,
// and parity_err when UART_PARITY_EN is defined. master = receiver, slave = consumer.
interface uart_host_rx_if;

  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frame_err;
  logic       overrun;
`ifdef UART_PARITY_EN
  logic       parity_err;
`endif

  modport master (
    input  out_ready,
    output out_data, out_valid, frame_err, overrun
`ifdef UART_PARITY_EN
    , parity_err
`endif
  );

  modport slave (
    output out_ready,
    input  out_data, out_valid, frame_err, overrun
`ifdef UART_PARITY_EN
    , parity_err
`endif
  );

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divides clk down to the 16x oversampling tick.
// Ports: clk, rst (sync, active-high), clear (restart the divider phase), tick (one-cycle pulse).
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_TICK = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

  logic [CW-1:0] cnt;

  // Free-running divider; clear re-phases it to the start-bit edge.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_host_rx.sv
// uart_host_rx: host-side UART receiver (16x oversampling, 8N1) with a byte FIFO.
// Ports: clk, rst (sync, active-high), rx (async serial line, idle 1),
// bus (uart_host_rx_if.master: out_data/out_valid/out_ready, frame_err, overrun[, parity_err]).
// Build macro UART_PARITY_EN: 8E1 framing with PARITY state and parity_err output.
module uart_host_rx import uart_pkg::*; #(
  parameter int unsigned SYS_CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned FIFO_ADDR_W  = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  uart_host_rx_if.master bus
);

  localparam int unsigned CPT    = clks_per_tick(SYS_CLK_FREQ, BAUD_RATE);
  localparam int unsigned TCNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIDX_W = $clog2(DATA_BITS);
  localparam int unsigned DEPTH  = 2 ** FIFO_ADDR_W;
  localparam int unsigned CNT_W  = FIFO_ADDR_W + 1;
  localparam logic [TCNT_W-1:0] TCNT_MID  = TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(OVERSAMPLE - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

  logic rx_meta, rx_s;
  logic tick;

  rx_state_e             state_q, state_d;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
  logic [BIDX_W-1:0]     bidx_q, bidx_d;
  logic [DATA_BITS-1:0]  shreg_q, shreg_d;
`ifdef UART_PARITY_EN
  logic                  par_q, par_d;
`endif

  logic start_c, stop_sample_c, parity_ok_c, byte_ok_c, frame_bad_c, parity_bad_c;

  logic [DATA_BITS-1:0]   mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d, cnt_after_pop;
  logic                   pop_c, push_c, overrun_c;
  logic [DATA_BITS-1:0]   head_d;

  // Two-flop synchronizer, idle-high out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  uart_baud_tick #(.CLKS_PER_TICK(CPT)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (start_c),
    .tick  (tick)
  );

  // FSM state register with its datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      bidx_q  <= '0;
      shreg_q <= '0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bidx_q  <= bidx_d;
      shreg_q <= shreg_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state: START checks mid start bit, later states sample at tick count 15.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bidx_d  = bidx_q;
    shreg_d = shreg_q;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          tcnt_d  = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tcnt_q == TCNT_MID) begin
            tcnt_d  = '0;
            bidx_d  = '0;
            state_d = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          tcnt_d = tcnt_q + TCNT_W'(1);
          if (tcnt_q == TCNT_LAST) begin
            tcnt_d  = '0;
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            bidx_d  = bidx_q + BIDX_W'(1);
            if (bidx_q == BIDX_LAST) begin
`ifdef UART_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          tcnt_d = tcnt_q + TCNT_W'(1);
          if (tcnt_q == TCNT_LAST) begin
            tcnt_d  = '0;
            par_d   = rx_s;
            state_d = ST_STOP;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          tcnt_d = tcnt_q + TCNT_W'(1);
          if (tcnt_q == TCNT_LAST) begin
            tcnt_d  = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: divider re-phase on start detect and the frame-completion verdict.
  always_comb begin
    start_c       = (state_q == ST_IDLE) && !rx_s;
    stop_sample_c = (state_q == ST_STOP) && tick && (tcnt_q == TCNT_LAST);
`ifdef UART_PARITY_EN
    parity_ok_c   = (par_q == ^shreg_q);
`else
    parity_ok_c   = 1'b1;
`endif
    frame_bad_c   = stop_sample_c && !rx_s;
    parity_bad_c  = stop_sample_c && rx_s && !parity_ok_c;
    byte_ok_c     = stop_sample_c && rx_s && parity_ok_c;
  end

  // FIFO control: fullness is judged after a same-cycle pop.
  always_comb begin
    pop_c         = bus.out_valid && bus.out_ready;
    cnt_after_pop = count_q - CNT_W'(pop_c);
    push_c        = byte_ok_c && (cnt_after_pop != FULL_CNT);
    overrun_c     = byte_ok_c && (cnt_after_pop == FULL_CNT);
    count_d       = cnt_after_pop + CNT_W'(push_c);
    rd_ptr_d      = rd_ptr_q + FIFO_ADDR_W'(pop_c);
    wr_ptr_d      = wr_ptr_q + FIFO_ADDR_W'(push_c);
    head_d        = bus.out_data;
    if (cnt_after_pop != '0) begin
      head_d = mem[rd_ptr_d];
    end else if (push_c) begin
      head_d = shreg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c && !rst) begin
      mem[wr_ptr_q] <= shreg_q;
    end
  end

  // Registered FIFO state, output head and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q        <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.frame_err  <= 1'b0;
      bus.overrun    <= 1'b0;
`ifdef UART_PARITY_EN
      bus.parity_err <= 1'b0;
`endif
    end else begin
      count_q        <= count_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      bus.out_valid  <= (count_d != '0);
      bus.out_data   <= head_d;
      bus.frame_err  <= frame_bad_c;
      bus.overrun    <= overrun_c;
`ifdef UART_PARITY_EN
      bus.parity_err <= parity_bad_c;
`endif
    end
  end

`ifndef UART_PARITY_EN
  logic unused_c;
  assign unused_c = parity_bad_c;
`endif

endmodule

// File: doc/uart_host_rx.md
# uart_host_rx

Host-side UART receiver that sits on the `Tx` line of `riscv_top` and turns the CPU's serial output back into bytes. It is the receiving end of the `Tx` link: 16x oversampling, 8N1 framing, synchronous active-high reset, a small byte FIFO, and a valid/ready output port. It is synthesizable and is also instantiated in simulation to capture program output instead of leaving `Tx` unconnected.

## Interface
- `SYS_CLK_FREQ`, default 100_000_000: `clk` frequency in Hz.
- `BAUD_RATE`, default 115200: line rate.
- `FIFO_ADDR_W`, default 3: FIFO depth is 2^`FIFO_ADDR_W` (8 entries).
- `clk` in 1: the only clock; every flop is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx` in 1: serial line, asynchronous to `clk`; idle level is 1.
- `out_data` out 8: byte at the FIFO head.
- `out_valid` out 1: FIFO is non-empty.
- `out_ready` in 1: consumer pops the head when `out_valid && out_ready`.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled as 0.
- `overrun` out 1: one-cycle pulse when a good byte arrives with the FIFO full.
- `parity_err` out 1: one-cycle pulse on a parity mismatch. Present only with `UART_PARITY_EN`.

## Operation
- `rx` passes through a 2-flop synchronizer that resets to 1. The FSM sees only the synchronized value `rx_s`.
- Tick generator: `CLKS_PER_TICK = SYS_CLK_FREQ / (BAUD_RATE*16)`, integer division, minimum 1. It emits a one-cycle `tick`. Its counter is cleared by `rst` and on every IDLE→START transition, so sampling is phase-aligned to the start edge.
- FSM states are IDLE, START, DATA, PARITY (only with `UART_PARITY_EN`) and STOP. There is a 4-bit tick counter `tcnt` and a 3-bit bit index `bidx`.
  - IDLE: when `rx_s` is 0, clear `tcnt` and go to START.
  - START: at `tcnt` = 7, re-sample `rx_s`. If it is 0, clear `tcnt` and go to DATA. If it is 1, this is a glitch: go to IDLE and produce no output and no error.
  - DATA: every 16 ticks (mid-bit), shift `rx_s` into the shift register, LSB first. After `bidx` = 7, go to PARITY, or to STOP when parity is compiled out.
  - PARITY: mid-bit sample. Compare it against the even parity of the data byte.
  - STOP: mid-bit sample, then return to IDLE in the same step. The line is not re-checked for a second stop bit.
- Completion happens on the STOP sample edge:
  - stop = 0: pulse `frame_err` and discard the byte.
  - stop = 1 but parity bad: pulse `parity_err` and discard the byte.
  - stop = 1, parity good (or parity disabled), FIFO not full: push the byte.
  - stop = 1, parity good (or parity disabled), FIFO full: pulse `overrun`, drop the new byte, and leave the FIFO contents unchanged.
- If push and pop happen in the same cycle while full, the push is accepted: fullness is evaluated after the pop. The same-cycle push/pop rule applies at any occupancy, and the count is unchanged.
- A FIFO is empty when it has no entries to pop; a pop while empty is ignored.
- Pointers are `FIFO_ADDR_W` bits wide and wrap modulo depth. Occupancy is tracked by a `FIFO_ADDR_W+1`-bit count.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `frame_err`=0, `overrun`=0, `parity_err`=0. FSM in IDLE, FIFO empty, synchronizer outputs 1.
- Synchronizer latency is 2 cycles.
- A push on edge N makes `out_valid`=1 from edge N+1.
- `out_data` is registered, is valid whenever `out_valid` is 1, and updates on the edge after a pop.
- A pop on edge N makes the next entry visible at N+1.
- All error pulses are exactly 1 cycle wide and align with the STOP sample edge + 1.
- Asserting `rst` mid-frame abandons the frame, empties the FIFO, and returns to IDLE on the next edge. A 0 level on `rx` after reset is treated as a new start bit.

## Configuration
- `UART_PARITY_EN`: when defined, frames are 8E1. The PARITY state and the `parity_err` port are compiled in.
- When it is not defined, frames are 8N1. The PARITY state and `parity_err` are absent, and STOP follows DATA directly.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum;
  - `OVERSAMPLE` = 16;
  - `DATA_BITS` = 8;
  - the `CLKS_PER_TICK` computation function, shared with the CPU-side UART transmitter.
- One sub-module, `uart_baud_tick`, containing the tick counter, its `clear` input, and the `tick` output.
- The FIFO is inline.

## Test plan
All scenarios use `SYS_CLK_FREQ`=1_843_200 and `BAUD_RATE`=115200, so `CLKS_PER_TICK`=1 and one bit lasts 16 clocks.
- Single byte: send 0xA5 in 8N1 with `out_ready`=0 → `out_valid` rises 1 cycle after the stop sample, `out_data`=0xA5, no error pulses.
- Burst into a full FIFO: send 9 bytes 0x00–0x08 back-to-back with `out_ready`=0 → bytes 0x00–0x07 are held, `overrun` pulses once on byte 0x08, then draining yields 0x00…0x07 in order.
- Stop error: send 0x3C with stop bit = 0 → `frame_err` pulses for 1 cycle and `out_valid` stays 0.
- Glitch: hold `rx` low for 5 clocks, then high → FSM returns to IDLE, no output, no error.
- Full with simultaneous pop: with the FIFO full, assert `out_ready` on the same edge as the push of 0x55 → no `overrun`, count stays 8, and 0x55 is the last byte read out.
- Mid-frame reset: assert `rst` for 1 cycle at bit 4 of 0xFF → `out_valid`=0, all errors 0. The next frame, 0x12, is received correctly.
